chan_mode_counter: RTL and testbench

- Parametrised multi-channel counter engine; the successor to the single-constant, single-enum package-reference block.
- Each channel runs a small state machine from a shared command enum.
- Channels count up or down by a configurable step, saturate at programmable bounds and raise a one-cycle done pulse.
- Sits behind a valid/ready command port. Downstream logic reads the packed counts and run flags.

---
 rtl/chan_mode_counter.sv | 166 ++++++++++++++++
 tb/tb_chan_mode_counter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/chan_mode_counter.sv
// chan_mode_counter
//   Multi-channel up/down counter engine behind a valid/ready command port.
//   Each channel has its own IDLE/RUN/DONE state machine, steps by STEP per
//   cycle while running, saturates at LIMIT (up) or 0 (down) and pulses its
//   done bit for one cycle when it reaches the bound.
//
// Ports
//   i_clk, i_rst       clock (rising edge) and synchronous active-high reset
//   i_cmd_valid        command valid; held by the source until accepted
//   o_cmd_ready        command ready; low for the one cycle after acceptance
//   i_cmd_ch           target channel (out-of-range channels are dropped)
//   i_cmd_op           NOP=0, LOAD=1, START=2, STOP=3
//   i_cmd_dir          START direction, 0 = up, 1 = down
//   i_cmd_data         LOAD value (clamped to LIMIT)
//   o_count            packed counts, channel k at [k*WIDTH +: WIDTH]
//   o_running          per-channel RUN flag
//   o_done             per-channel one-cycle bound-reached pulse
module chan_mode_counter #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int LIMIT = 2**WIDTH - 1,
    localparam int CHW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [CHW-1:0]        i_cmd_ch,
    input  logic [1:0]            i_cmd_op,
    input  logic                  i_cmd_dir,
    input  logic [WIDTH-1:0]      i_cmd_data,
    output logic [N_CH*WIDTH-1:0] o_count,
    output logic [N_CH-1:0]       o_running,
    output logic [N_CH-1:0]       o_done
);

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_START = 2'd2,
        OP_STOP  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] LIM_V  = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

    // LOAD values above the upper bound are pulled down to it
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > LIM_V) ? LIM_V : v;
    endfunction

    // one extra bit so count+STEP can never wrap before the bound compare
    function automatic logic [WIDTH:0] up_sum(input logic [WIDTH-1:0] c);
        return {1'b0, c} + {1'b0, STEP_V};
    endfunction

    // Command latch: one command in flight; its presence also blocks ready
    logic             pend_q, pend_d;
    logic [CHW-1:0]   cmd_ch_q, cmd_ch_d;
    op_e              cmd_op_q, cmd_op_d;
    logic             cmd_dir_q, cmd_dir_d;
    logic [WIDTH-1:0] cmd_data_q, cmd_data_d;

    // Per-channel state
    state_e           state_q [N_CH];
    state_e           state_d [N_CH];
    logic             dir_q   [N_CH];
    logic             dir_d   [N_CH];
    logic [WIDTH-1:0] cnt_q   [N_CH];
    logic [WIDTH-1:0] cnt_d   [N_CH];
    logic [N_CH-1:0]  done_q, done_d;

    logic             accept;

    always_comb begin
        accept     = i_cmd_valid && !pend_q;
        pend_d     = accept;
        cmd_ch_d   = accept ? i_cmd_ch   : cmd_ch_q;
        cmd_op_d   = accept ? op_e'(i_cmd_op) : cmd_op_q;
        cmd_dir_d  = accept ? i_cmd_dir  : cmd_dir_q;
        cmd_data_d = accept ? i_cmd_data : cmd_data_q;
        done_d     = '0;

        for (int k = 0; k < N_CH; k++) begin
            state_d[k] = state_q[k];
            dir_d[k]   = dir_q[k];
            cnt_d[k]   = cnt_q[k];

            // An applied command takes the place of this cycle's step.
            // Channel indices >= N_CH never match, so those commands vanish.
            if (pend_q && (int'(cmd_ch_q) == k) && (cmd_op_q != OP_NOP)) begin
                case (cmd_op_q)
                    OP_LOAD:  cnt_d[k] = clamp_load(cmd_data_q);
                    OP_START: begin
                        dir_d[k]   = cmd_dir_q;
                        state_d[k] = ST_RUN;
                    end
                    OP_STOP:  state_d[k] = ST_IDLE;
                    default:  ;
                endcase
            end else if (state_q[k] == ST_RUN) begin
                if (!dir_q[k]) begin
                    if (up_sum(cnt_q[k]) >= {1'b0, LIM_V}) begin
                        cnt_d[k]   = LIM_V;
                        state_d[k] = ST_DONE;
                        done_d[k]  = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + STEP_V;
                    end
                end else begin
                    if (cnt_q[k] <= STEP_V) begin
                        cnt_d[k]   = '0;
                        state_d[k] = ST_DONE;
                        done_d[k]  = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] - STEP_V;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend_q <= 1'b0;
            done_q <= '0;
            for (int k = 0; k < N_CH; k++) begin
                state_q[k] <= ST_IDLE;
                dir_q[k]   <= 1'b0;
                cnt_q[k]   <= '0;
            end
        end else begin
            pend_q <= pend_d;
            done_q <= done_d;
            for (int k = 0; k < N_CH; k++) begin
                state_q[k] <= state_d[k];
                dir_q[k]   <= dir_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

    // Command fields only matter while pend_q is set, so they carry no reset
    always_ff @(posedge i_clk) begin
        cmd_ch_q   <= cmd_ch_d;
        cmd_op_q   <= cmd_op_d;
        cmd_dir_q  <= cmd_dir_d;
        cmd_data_q <= cmd_data_d;
    end

    assign o_cmd_ready = !pend_q;
    assign o_done      = done_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_out
        assign o_count[k*WIDTH +: WIDTH] = cnt_q[k];
        assign o_running[k]              = (state_q[k] == ST_RUN);
    end

endmodule

// File: tb/tb_chan_mode_counter.sv
// tb_chan_mode_counter
//   Two instances share one command stream: A uses STEP=1/LIMIT=255, B uses
//   STEP=3/LIMIT=200. A reference model updates at every rising edge and
//   queues the outputs it expects; a monitor on the falling edge pops each
//   entry and compares it with both instances.
module tb_chan_mode_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [1:0]  cmd_ch;
    logic [1:0]  cmd_op;
    logic        cmd_dir;
    logic [7:0]  cmd_data;

    logic        rdy_a, rdy_b;
    logic [31:0] count_a, count_b;
    logic [3:0]  run_a, run_b, done_a, done_b;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    chan_mode_counter #(.N_CH(4), .WIDTH(8), .STEP(1), .LIMIT(255)) u_a (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(valid), .o_cmd_ready(rdy_a),
        .i_cmd_ch(cmd_ch), .i_cmd_op(cmd_op), .i_cmd_dir(cmd_dir),
        .i_cmd_data(cmd_data), .o_count(count_a), .o_running(run_a),
        .o_done(done_a)
    );

    chan_mode_counter #(.N_CH(4), .WIDTH(8), .STEP(3), .LIMIT(200)) u_b (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(valid), .o_cmd_ready(rdy_b),
        .i_cmd_ch(cmd_ch), .i_cmd_op(cmd_op), .i_cmd_dir(cmd_dir),
        .i_cmd_data(cmd_data), .o_count(count_b), .o_running(run_b),
        .o_done(done_b)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        ready;
        logic [31:0] count_a;
        logic [3:0]  run_a;
        logic [3:0]  done_a;
        logic [31:0] count_b;
        logic [3:0]  run_b;
        logic [3:0]  done_b;
    } exp_t;

    exp_t exp_q[$];

    // per instance m: 0 idle, 1 running, 2 at bound
    int step_p [2] = '{1, 3};
    int lim_p  [2] = '{255, 200};
    int cnt    [2][4];
    int st     [2][4];
    int dirm   [2][4];
    int dn     [2][4];
    int pend   [2];
    int p_ch [2], p_op [2], p_dir [2], p_data [2];

    always @(posedge clk) begin
        exp_t e;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                pend[m] = 0;
                for (int k = 0; k < 4; k++) begin
                    cnt[m][k] = 0; st[m][k] = 0; dirm[m][k] = 0; dn[m][k] = 0;
                end
            end else begin
                int applying;
                applying = pend[m];
                for (int k = 0; k < 4; k++) begin
                    dn[m][k] = 0;
                    if (applying != 0 && p_ch[m] == k && p_op[m] != 0) begin
                        if (p_op[m] == 1)
                            cnt[m][k] = (p_data[m] > lim_p[m]) ? lim_p[m] : p_data[m];
                        else if (p_op[m] == 2) begin
                            dirm[m][k] = p_dir[m];
                            st[m][k]   = 1;
                        end else
                            st[m][k] = 0;
                    end else if (st[m][k] == 1) begin
                        if (dirm[m][k] == 0) begin
                            if (cnt[m][k] + step_p[m] >= lim_p[m]) begin
                                cnt[m][k] = lim_p[m]; st[m][k] = 2; dn[m][k] = 1;
                            end else
                                cnt[m][k] = cnt[m][k] + step_p[m];
                        end else begin
                            if (cnt[m][k] <= step_p[m]) begin
                                cnt[m][k] = 0; st[m][k] = 2; dn[m][k] = 1;
                            end else
                                cnt[m][k] = cnt[m][k] - step_p[m];
                        end
                    end
                end
                // a new command can only be taken while nothing is pending
                pend[m] = (valid && applying == 0) ? 1 : 0;
                if (pend[m] != 0) begin
                    p_ch[m] = int'(cmd_ch); p_op[m] = int'(cmd_op);
                    p_dir[m] = int'(cmd_dir); p_data[m] = int'(cmd_data);
                end
            end
        end
        e.ready = (pend[0] == 0);
        for (int k = 0; k < 4; k++) begin
            e.count_a[k*8 +: 8] = 8'(cnt[0][k]);
            e.run_a[k]          = (st[0][k] == 1);
            e.done_a[k]         = (dn[0][k] != 0);
            e.count_b[k*8 +: 8] = 8'(cnt[1][k]);
            e.run_b[k]          = (st[1][k] == 1);
            e.done_b[k]         = (dn[1][k] != 0);
        end
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ready_a", 32'(rdy_a), 32'(e.ready));
            chk("ready_b", 32'(rdy_b), 32'(e.ready));
            chk("count_a", count_a, e.count_a);
            chk("running_a", 32'(run_a), 32'(e.run_a));
            chk("done_a", 32'(done_a), 32'(e.done_a));
            chk("count_b", count_b, e.count_b);
            chk("running_b", 32'(run_b), 32'(e.run_b));
            chk("done_b", 32'(done_b), 32'(e.done_b));
        end
    end

    // ---------------- stimulus ----------------
    // Leaves valid high so consecutive sends are back-to-back.
    task automatic send(input int ch, input int op, input int dir, input int data);
        int guard;
        guard    = 0;
        valid    = 1'b1;
        cmd_ch   = 2'(ch);
        cmd_op   = 2'(op);
        cmd_dir  = 1'(dir);
        cmd_data = 8'(data);
        while (!rdy_a && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 20) begin
            n_chk++;
            $display("FAIL handshake_timeout: ready stayed %0b, expected 1", rdy_a);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        valid = 1'b0;
        rst   = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; cmd_ch = '0; cmd_op = '0; cmd_dir = 1'b0; cmd_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // ch2 from 250 up to the bound
        send(2, 1, 0, 250);
        send(2, 2, 0, 0);
        idle(8);
        send(2, 0, 0, 0);          // NOP on a finished channel
        idle(2);

        // ch0 up near the bound, ch1 down through zero
        send(0, 1, 0, 195);
        send(0, 2, 0, 0);
        send(1, 1, 0, 2);
        send(1, 2, 1, 0);
        idle(6);

        // reload a running channel
        send(3, 1, 0, 100);
        send(3, 2, 0, 0);
        idle(2);
        send(3, 1, 0, 10);
        idle(3);

        // stop mid-run, then restart downwards
        send(1, 1, 0, 30);
        send(1, 2, 0, 0);
        idle(5);
        send(1, 3, 0, 0);
        idle(3);
        send(1, 2, 1, 0);
        idle(4);

        // reset with a command still pending
        send(0, 2, 0, 0);
        send(2, 1, 0, 77);
        pulse_reset();
        idle(3);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 49) == 0)
                pulse_reset();
            else
                send(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                     int'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 6)));
        end

        idle(4);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
